// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the external 8-bit ALU: accepts one command, runs a binary
// pass plus optional decimal adjust passes, and returns the result with N/Z/C/V flags.
module alu_sequencer #(
    parameter logic DEC_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_cmd,
    input  logic [7:0] req_acc,
    input  logic [7:0] req_mem,
    input  logic       req_c,
    input  logic       req_v,
    input  logic       req_d,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    output logic       alu_c_in,
    input  logic [7:0] alu_y,
    input  logic       alu_c_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_n,
    output logic       rsp_z,
    output logic       rsp_c,
    output logic       rsp_v,
    output logic       rsp_wr,
    output logic       rsp_err
);

    typedef enum logic [2:0] {IDLE, EXEC, ADJ_LO, ADJ_HI, RESP} state_t;

    localparam logic [3:0] CMD_ADC = 4'h0;
    localparam logic [3:0] CMD_SBC = 4'h1;
    localparam logic [3:0] CMD_ORA = 4'h2;
    localparam logic [3:0] CMD_AND = 4'h3;
    localparam logic [3:0] CMD_EOR = 4'h4;
    localparam logic [3:0] CMD_INC = 4'h5;
    localparam logic [3:0] CMD_DEC = 4'h6;
    localparam logic [3:0] CMD_ASL = 4'h7;
    localparam logic [3:0] CMD_ROL = 4'h8;
    localparam logic [3:0] CMD_ROR = 4'h9;
    localparam logic [3:0] CMD_LSR = 4'hA;
    localparam logic [3:0] CMD_BIT = 4'hB;
    localparam logic [3:0] CMD_CMP = 4'hC;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic       c_in;
    } drive_t;

    typedef struct packed {
        logic [7:0] result;
        logic       n;
        logic       z;
        logic       c;
        logic       v;
        logic       wr;
    } flags_t;

    localparam drive_t DRIVE_IDLE = '{a: 8'h00, b: 8'h00, op: 4'hF, c_in: 1'b0};

    // ALU lines for the first (binary) pass of each legal command
    function automatic drive_t exec_drive(input logic [3:0] cmd, input logic [7:0] acc,
                                          input logic [7:0] mem, input logic c);
        drive_t d;
        d = DRIVE_IDLE;
        case (cmd)
            CMD_ADC: d = '{a: acc, b: mem,   op: 4'h0, c_in: c};
            CMD_SBC: d = '{a: mem, b: acc,   op: 4'h1, c_in: ~c};
            CMD_ORA: d = '{a: acc, b: mem,   op: 4'h2, c_in: 1'b0};
            CMD_AND: d = '{a: acc, b: mem,   op: 4'h3, c_in: 1'b0};
            CMD_EOR: d = '{a: acc, b: mem,   op: 4'h4, c_in: 1'b0};
            CMD_INC: d = '{a: mem, b: 8'h00, op: 4'h5, c_in: 1'b1};
            CMD_DEC: d = '{a: mem, b: 8'h00, op: 4'h6, c_in: 1'b1};
            CMD_ASL: d = '{a: mem, b: 8'h00, op: 4'h7, c_in: 1'b0};
            CMD_ROL: d = '{a: mem, b: 8'h00, op: 4'h8, c_in: c};
            CMD_ROR: d = '{a: mem, b: 8'h00, op: 4'h9, c_in: c};
            CMD_LSR: d = '{a: mem, b: 8'h00, op: 4'h9, c_in: 1'b0};
            CMD_BIT: d = '{a: acc, b: mem,   op: 4'h3, c_in: 1'b0};
            CMD_CMP: d = '{a: mem, b: acc,   op: 4'h1, c_in: 1'b0};
            default: d = DRIVE_IDLE;
        endcase
        return d;
    endfunction

    // Result and flags of a binary pass; SBC/CMP ALU carry-out is a borrow
    function automatic flags_t binary_flags(input logic [3:0] cmd, input logic [7:0] acc,
                                            input logic [7:0] mem, input logic c,
                                            input logic v, input logic [7:0] y,
                                            input logic co);
        flags_t f;
        f.result = y;
        f.c      = c;
        f.v      = v;
        f.wr     = 1'b1;
        case (cmd)
            CMD_ADC: begin
                f.c = co;
                f.v = (acc[7] == mem[7]) && (y[7] != acc[7]);
            end
            CMD_SBC: begin
                f.c = ~co;
                f.v = (acc[7] != mem[7]) && (y[7] != acc[7]);
            end
            CMD_CMP: begin
                f.c  = ~co;
                f.wr = 1'b0;
            end
            CMD_ASL, CMD_ROL, CMD_ROR, CMD_LSR: f.c = co;
            CMD_BIT: begin
                f.result = acc;
                f.v      = mem[6];
                f.wr     = 1'b0;
            end
            default: f.wr = 1'b1;
        endcase
        f.n = (cmd == CMD_BIT) ? mem[7] : f.result[7];
        f.z = (cmd == CMD_BIT) ? ((acc & mem) == 8'h00) : (f.result == 8'h00);
        return f;
    endfunction

    state_t     state_r;
    logic [3:0] cmd_r;
    logic [7:0] acc_r, mem_r, r1_r, r2_r;
    logic       c_r, v_r, dec_r, h_gt9_r, lb_r, c1_r, c2_r, v1_r;
    logic       rsp_valid_r, rsp_n_r, rsp_z_r, rsp_c_r, rsp_v_r, rsp_wr_r, rsp_err_r;
    logic [7:0] rsp_result_r;

    drive_t     drv_s;
    flags_t     bin_s;
    logic       hi_s;
    logic [4:0] half_sum_s;
    logic       lo_borrow_s;
    logic       legal_s;

    // Decode ALU drive from the current state and the latched command/intermediates
    always_comb begin
        drv_s       = DRIVE_IDLE;
        hi_s        = c1_r | c2_r | (r2_r[7:4] > 4'd9);
        half_sum_s  = {1'b0, req_acc[3:0]} + {1'b0, req_mem[3:0]} + {4'b0000, req_c};
        lo_borrow_s = {1'b0, req_acc[3:0]} < ({1'b0, req_mem[3:0]} + {4'b0000, ~req_c});
        legal_s     = (req_cmd <= CMD_CMP);
        bin_s       = binary_flags(cmd_r, acc_r, mem_r, c_r, v_r, alu_y, alu_c_out);
        case (state_r)
            EXEC: drv_s = exec_drive(cmd_r, acc_r, mem_r, c_r);
            ADJ_LO: begin
                if (cmd_r == CMD_ADC) begin
                    drv_s = '{a: r1_r, b: (h_gt9_r ? 8'h06 : 8'h00), op: 4'h0, c_in: 1'b0};
                end else begin
                    drv_s = '{a: (lb_r ? 8'h06 : 8'h00), b: r1_r, op: 4'h1, c_in: 1'b0};
                end
            end
            ADJ_HI: begin
                if (cmd_r == CMD_ADC) begin
                    drv_s = '{a: r2_r, b: (hi_s ? 8'h60 : 8'h00), op: 4'h0, c_in: 1'b0};
                end else begin
                    drv_s = '{a: (c1_r ? 8'h60 : 8'h00), b: r2_r, op: 4'h1, c_in: 1'b0};
                end
            end
            default: drv_s = DRIVE_IDLE;
        endcase
    end

    // Sequencer FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cmd_r        <= 4'h0;
            acc_r        <= 8'h00;
            mem_r        <= 8'h00;
            r1_r         <= 8'h00;
            r2_r         <= 8'h00;
            c_r          <= 1'b0;
            v_r          <= 1'b0;
            dec_r        <= 1'b0;
            h_gt9_r      <= 1'b0;
            lb_r         <= 1'b0;
            c1_r         <= 1'b0;
            c2_r         <= 1'b0;
            v1_r         <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= 8'h00;
            rsp_n_r      <= 1'b0;
            rsp_z_r      <= 1'b0;
            rsp_c_r      <= 1'b0;
            rsp_v_r      <= 1'b0;
            rsp_wr_r     <= 1'b0;
            rsp_err_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        cmd_r   <= req_cmd;
                        acc_r   <= req_acc;
                        mem_r   <= req_mem;
                        c_r     <= req_c;
                        v_r     <= req_v;
                        h_gt9_r <= (half_sum_s > 5'd9);
                        lb_r    <= lo_borrow_s;
                        dec_r   <= DEC_EN & req_d & ((req_cmd == CMD_ADC) || (req_cmd == CMD_SBC));
                        if (legal_s) begin
                            state_r <= EXEC;
                        end else begin
                            state_r      <= RESP;
                            rsp_valid_r  <= 1'b1;
                            rsp_result_r <= req_acc;
                            rsp_n_r      <= 1'b0;
                            rsp_z_r      <= 1'b0;
                            rsp_c_r      <= req_c;
                            rsp_v_r      <= req_v;
                            rsp_wr_r     <= 1'b0;
                            rsp_err_r    <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    r1_r <= alu_y;
                    c1_r <= alu_c_out;
                    v1_r <= bin_s.v;
                    if (dec_r) begin
                        state_r <= ADJ_LO;
                    end else begin
                        state_r      <= RESP;
                        rsp_valid_r  <= 1'b1;
                        rsp_result_r <= bin_s.result;
                        rsp_n_r      <= bin_s.n;
                        rsp_z_r      <= bin_s.z;
                        rsp_c_r      <= bin_s.c;
                        rsp_v_r      <= bin_s.v;
                        rsp_wr_r     <= bin_s.wr;
                        rsp_err_r    <= 1'b0;
                    end
                end
                ADJ_LO: begin
                    r2_r    <= alu_y;
                    c2_r    <= alu_c_out;
                    state_r <= ADJ_HI;
                end
                ADJ_HI: begin
                    // Overflow in decimal mode is taken from the binary pass
                    state_r      <= RESP;
                    rsp_valid_r  <= 1'b1;
                    rsp_result_r <= alu_y;
                    rsp_n_r      <= alu_y[7];
                    rsp_z_r      <= (alu_y == 8'h00);
                    rsp_c_r      <= (cmd_r == CMD_ADC) ? hi_s : ~c1_r;
                    rsp_v_r      <= v1_r;
                    rsp_wr_r     <= 1'b1;
                    rsp_err_r    <= 1'b0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_r     <= IDLE;
                        rsp_valid_r <= 1'b0;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_r == IDLE) && !reset;
    assign alu_a      = drv_s.a;
    assign alu_b      = drv_s.b;
    assign alu_op     = drv_s.op;
    assign alu_c_in   = drv_s.c_in;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = rsp_result_r;
    assign rsp_n      = rsp_n_r;
    assign rsp_z      = rsp_z_r;
    assign rsp_c      = rsp_c_r;
    assign rsp_v      = rsp_v_r;
    assign rsp_wr     = rsp_wr_r;
    assign rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a behavioural ALU closes the loop, a reference
// model predicts each response, and a monitor checks values, latency and hold behaviour.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset, req_valid, req_ready, req_c, req_v, req_d;
    logic [3:0] req_cmd, alu_op;
    logic [7:0] req_acc, req_mem, alu_a, alu_b, alu_y, rsp_result;
    logic       alu_c_in, alu_c_out, rsp_valid, rsp_ready;
    logic       rsp_n, rsp_z, rsp_c, rsp_v, rsp_wr, rsp_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] result;
        logic       n, z, c, v, wr, err;
        int         due;
    } exp_t;

    exp_t q[$];

    alu_sequencer #(.DEC_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_acc(req_acc), .req_mem(req_mem), .req_c(req_c),
        .req_v(req_v), .req_d(req_d), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_c_in(alu_c_in), .alu_y(alu_y), .alu_c_out(alu_c_out), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_n(rsp_n), .rsp_z(rsp_z),
        .rsp_c(rsp_c), .rsp_v(rsp_v), .rsp_wr(rsp_wr), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational ALU the sequencer drives (op 1 computes b - a - c_in, c_out = borrow)
    always_comb begin
        logic [8:0] t;
        t = 9'h000;
        alu_y = 8'h00;
        alu_c_out = 1'b0;
        case (alu_op)
            4'h0: begin t = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_c_in}; alu_y = t[7:0]; alu_c_out = t[8]; end
            4'h1: begin t = {1'b0, alu_b} - {1'b0, alu_a} - {8'h00, alu_c_in}; alu_y = t[7:0]; alu_c_out = t[8]; end
            4'h2: alu_y = alu_a | alu_b;
            4'h3: alu_y = alu_a & alu_b;
            4'h4: alu_y = alu_a ^ alu_b;
            4'h5: alu_y = alu_a + {7'h00, alu_c_in};
            4'h6: alu_y = alu_a - {7'h00, alu_c_in};
            4'h7: {alu_c_out, alu_y} = {alu_a, 1'b0};
            4'h8: {alu_c_out, alu_y} = {alu_a, alu_c_in};
            4'h9: {alu_y, alu_c_out} = {alu_c_in, alu_a};
            default: alu_y = 8'h00;
        endcase
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: 6502-style semantics in plain integer arithmetic
    function automatic exp_t model(input logic [3:0] cmd, input logic [7:0] acc, input logic [7:0] mem,
                                   input logic c, input logic v, input logic d);
        exp_t e;
        int a, m, ci, s, r1, r2, lo, t, res;
        logic hi, lb;
        a = int'(acc); m = int'(mem); ci = c ? 1 : 0;
        e.c = c; e.v = v; e.wr = 1'b1; e.err = 1'b0; e.due = 0;
        res = 0;
        case (cmd)
            4'h0: begin
                s = a + m + ci; res = s & 255; e.c = (s > 255);
                e.v = (((a ^ res) & (m ^ res) & 128) != 0);
                if (d) begin
                    lo = (a & 15) + (m & 15) + ci;
                    t  = res + ((lo > 9) ? 6 : 0);
                    hi = (s > 255) || (t > 255) || (((t & 255) >> 4) > 9);
                    res = ((t & 255) + (hi ? 96 : 0)) & 255;
                    e.c = hi;
                end
            end
            4'h1: begin
                s = a - m - (1 - ci); r1 = s & 255; res = r1; e.c = (s >= 0);
                e.v = (((a ^ m) & (a ^ r1) & 128) != 0);
                if (d) begin
                    lb  = (a & 15) < ((m & 15) + (1 - ci));
                    r2  = (r1 - (lb ? 6 : 0)) & 255;
                    res = (r2 - ((s < 0) ? 96 : 0)) & 255;
                end
            end
            4'h2: res = a | m;
            4'h3: res = a & m;
            4'h4: res = a ^ m;
            4'h5: res = (m + 1) & 255;
            4'h6: res = (m - 1) & 255;
            4'h7: begin res = (m << 1) & 255; e.c = ((m >> 7) & 1) != 0; end
            4'h8: begin res = ((m << 1) | ci) & 255; e.c = ((m >> 7) & 1) != 0; end
            4'h9: begin res = (m >> 1) | (ci << 7); e.c = (m & 1) != 0; end
            4'hA: begin res = m >> 1; e.c = (m & 1) != 0; end
            4'hB: begin res = a; e.wr = 1'b0; end
            4'hC: begin res = (a - m) & 255; e.c = (a >= m); e.wr = 1'b0; end
            default: begin res = a; e.wr = 1'b0; e.err = 1'b1; end
        endcase
        e.result = 8'(res);
        e.n = res[7];
        e.z = (res == 0);
        if (cmd == 4'hB) begin
            e.n = mem[7]; e.v = mem[6]; e.z = ((a & m) == 0);
        end
        if (e.err) begin
            e.n = 1'b0; e.z = 1'b0;
        end
        return e;
    endfunction

    function automatic int latency(input logic [3:0] cmd, input logic d);
        if (cmd > 4'hC) return 1;
        if (d && (cmd <= 4'h1)) return 4;
        return 2;
    endfunction

    // Directed vectors {cmd, acc, mem, c, v, d}
    localparam int NDIR = 10;
    logic [3:0] dir_cmd [NDIR] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'hC, 4'hB, 4'h9, 4'hA, 4'hE};
    logic [7:0] dir_acc [NDIR] = '{8'h7F, 8'h99, 8'h45, 8'h00, 8'h50, 8'h10, 8'h0F, 8'h00, 8'h00, 8'h5A};
    logic [7:0] dir_mem [NDIR] = '{8'h01, 8'h01, 8'h38, 8'h01, 8'h01, 8'h20, 8'hC0, 8'h01, 8'h01, 8'h33};
    logic       dir_c   [NDIR] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       dir_d   [NDIR] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam int NTXN = 160;

    // Stimulus driver
    initial begin
        int  sent;
        logic accepted;
        exp_t e;
        reset = 1'b1; req_valid = 1'b0; req_cmd = 4'h0; req_acc = 8'h00; req_mem = 8'h00;
        req_c = 1'b0; req_v = 1'b0; req_d = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_result", rsp_result, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_alu_op", alu_op, 4'hF);
        reset = 1'b0;
        #1 chk("idle_req_ready", req_ready, 1);

        sent = 0;
        accepted = 1'b0;
        while (sent < NTXN || accepted) begin
            @(posedge clk); #1;
            if (accepted) begin
                req_valid = 1'b0;
                accepted = 1'b0;
            end
            if (!req_valid && sent < NTXN && $urandom_range(0, 3) != 0) begin
                if (sent < NDIR) begin
                    req_cmd = dir_cmd[sent]; req_acc = dir_acc[sent]; req_mem = dir_mem[sent];
                    req_c = dir_c[sent]; req_d = dir_d[sent]; req_v = 1'b0;
                end else begin
                    req_cmd = 4'($urandom_range(0, 15)); req_acc = 8'($urandom_range(0, 255));
                    req_mem = 8'($urandom_range(0, 255)); req_c = 1'($urandom_range(0, 1));
                    req_v = 1'($urandom_range(0, 1)); req_d = 1'($urandom_range(0, 1));
                end
                req_valid = 1'b1;
            end
            @(negedge clk);
            if (req_valid && req_ready) begin
                e = model(req_cmd, req_acc, req_mem, req_c, req_v, req_d);
                e.due = cyc + latency(req_cmd, req_d);
                q.push_back(e);
                sent++;
                accepted = 1'b1;
            end
        end

        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !rsp_valid) break;
        end
        chk("drain_queue_empty", q.size(), 0);

        // Abort a decimal ADC while in its low-nibble adjust pass
        @(posedge clk); #1;
        req_cmd = 4'h0; req_acc = 8'h99; req_mem = 8'h01; req_c = 1'b0; req_v = 1'b0; req_d = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        chk("abort_accept_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_exec_alu_a", alu_a, 8'h99);
        chk("abort_exec_alu_b", alu_b, 8'h01);
        @(posedge clk); #1;
        chk("abort_adjlo_alu_a", alu_a, 8'h9A);
        chk("abort_adjlo_alu_b", alu_b, 8'h06);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_alu_op_idle", alu_op, 4'hF);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_req_ready_in_reset", req_ready, 0);
        reset = 1'b0;
        #1 chk("abort_req_ready_after", req_ready, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Response monitor and scoreboard
    initial begin
        logic       in_rsp;
        logic [13:0] held;
        int         hold_cnt, nrsp;
        exp_t       e;
        in_rsp = 1'b0; held = 14'h0; hold_cnt = 0; nrsp = 0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_rsp = 1'b0;
            end else if (rsp_valid) begin
                if (!in_rsp) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("rsp_latency", cyc, e.due);
                        chk("rsp_result", rsp_result, e.result);
                        chk("rsp_n", rsp_n, e.n);
                        chk("rsp_z", rsp_z, e.z);
                        chk("rsp_c", rsp_c, e.c);
                        chk("rsp_v", rsp_v, e.v);
                        chk("rsp_wr", rsp_wr, e.wr);
                        chk("rsp_err", rsp_err, e.err);
                    end
                    in_rsp = 1'b1;
                    held = {rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_wr, rsp_err};
                    hold_cnt = (nrsp == 0 || $urandom_range(0, 3) == 0) ? 3 : $urandom_range(0, 1);
                    nrsp++;
                end else begin
                    chk("rsp_hold_stable", {rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_wr, rsp_err}, held);
                end
                chk("req_ready_in_resp", req_ready, 0);
            end
            rsp_ready = (hold_cnt == 0);
            if (hold_cnt > 0) hold_cnt--;
            if (rsp_valid && rsp_ready) in_rsp = 1'b0;
        end
    end

    // Watchdog
    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
